// File: rtl/softmax_sub_ctrl.sv
// softmax_sub_ctrl: sequencing controller for the softmax max-subtraction stage.
// Takes one N-element vector, finds its signed maximum serially, hands the vector
// and maximum to the external subtractor, then returns the subtractor result
// downstream with backpressure.
// Optional build macro SOFTMAX_SUB_CTRL_TIMEOUT_EN adds a WAIT-state timeout
// with a sticky o_err flag; without it o_err is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a vector; capture it on i_valid
// S_MAXS  | serial signed max scan, one element per cycle (N-1 cycles)
// S_ISSUE | single-cycle o_sub_valid pulse to the subtractor
// S_WAIT  | waiting for i_sub_valid from the subtractor
// S_OUT   | result held on o_data/o_max until i_ready
module softmax_sub_ctrl #(
  parameter int BIT_WIDTH   = 16,
  parameter int N           = 32,
  parameter int SUB_TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N*BIT_WIDTH-1:0] i_data,
  output logic                   o_sub_valid,
  output logic [N*BIT_WIDTH-1:0] o_sub_data,
  output logic [BIT_WIDTH-1:0]   o_sub_max,
  input  logic                   i_sub_valid,
  input  logic [N*BIT_WIDTH-1:0] i_sub_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [N*BIT_WIDTH-1:0] o_data,
  output logic [BIT_WIDTH-1:0]   o_max,
  output logic                   o_busy,
  output logic                   o_err
);

  // idx only ever holds 1..N-1
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MAXS, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic [N*BIT_WIDTH-1:0]   vec_q;
  logic [N*BIT_WIDTH-1:0]   data_q;
  logic [BIT_WIDTH-1:0]     max_q;
  logic [BIT_WIDTH-1:0]     omax_q;
  logic [IW-1:0]            idx_q;
  logic [BIT_WIDTH-1:0]     cur_elem;
  logic                     accept;
  logic                     tmo_hit;

  assign accept   = (state_q == S_IDLE) && i_valid;
  assign cur_elem = vec_q[int'(idx_q)*BIT_WIDTH +: BIT_WIDTH];

`ifdef SOFTMAX_SUB_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(SUB_TIMEOUT + 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;

  assign tmo_hit = !i_sub_valid && (tmo_q == TW'(1));
  assign o_err   = err_q;

  // WAIT-state down-counter, loaded on ISSUE; sticky error at terminal count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept)
        err_q <= 1'b0;
      if (state_q == S_ISSUE) begin
        tmo_q <= TW'(SUB_TIMEOUT);
      end else if (state_q == S_WAIT && !i_sub_valid) begin
        if (tmo_hit)
          err_q <= 1'b1;
        tmo_q <= tmo_q - TW'(1);
      end
    end
  end
`else
  logic unused_sub_timeout;

  assign tmo_hit            = 1'b0;
  assign o_err              = 1'b0;
  assign unused_sub_timeout = (SUB_TIMEOUT != 0);
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    o_ready     = 1'b0;
    o_sub_valid = 1'b0;
    o_valid     = 1'b0;
    o_busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid)
          state_d = (N == 1) ? S_ISSUE : S_MAXS;
      end
      S_MAXS: begin
        if (idx_q == IW'(N - 1))
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        o_sub_valid = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (i_sub_valid)
          state_d = S_OUT;
        else if (tmo_hit)
          state_d = S_IDLE;
      end
      S_OUT: begin
        o_valid = 1'b1;
        if (i_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Vector capture, serial signed max scan, and result capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vec_q  <= '0;
      max_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      omax_q <= '0;
    end else begin
      if (accept) begin
        vec_q <= i_data;
        max_q <= i_data[BIT_WIDTH-1:0];
        idx_q <= IW'(1);
      end else if (state_q == S_MAXS) begin
        // strict greater-than: ties keep the earlier maximum
        if ($signed(cur_elem) > $signed(max_q))
          max_q <= cur_elem;
        idx_q <= idx_q + IW'(1);
      end
      if (state_q == S_WAIT && i_sub_valid) begin
        data_q <= i_sub_data;
        omax_q <= max_q;
      end
    end
  end

  assign o_sub_data = vec_q;
  assign o_sub_max  = max_q;
  assign o_data     = data_q;
  assign o_max      = omax_q;

endmodule

// File: tb/tb_softmax_sub_ctrl.sv
// tb_softmax_sub_ctrl: randomized self-checking bench for softmax_sub_ctrl with
// an attached 2-cycle subtractor model ((x - max) >>> 2, Q2.14 -> Q4.12).
// Define SOFTMAX_SUB_CTRL_TIMEOUT_EN to also exercise the timeout path.
module tb_softmax_sub_ctrl;

  localparam int N  = 32;
  localparam int BW = 16;
  localparam int W  = N * BW;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_data;
  logic          o_sub_valid;
  logic [W-1:0]  o_sub_data;
  logic [BW-1:0] o_sub_max;
  logic          i_sub_valid;
  logic [W-1:0]  i_sub_data;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_data;
  logic [BW-1:0] o_max;
  logic          o_busy;
  logic          o_err;

  int checks = 0;
  int errors = 0;

  logic         sub_en = 1'b1;
  logic         stray  = 1'b0;
  logic         p1, p2;
  logic [W-1:0] d1, d2;

  softmax_sub_ctrl #(.BIT_WIDTH(BW), .N(N), .SUB_TIMEOUT(15)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_sub_valid (o_sub_valid),
    .o_sub_data  (o_sub_data),
    .o_sub_max   (o_sub_max),
    .i_sub_valid (i_sub_valid),
    .i_sub_data  (i_sub_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_max       (o_max),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: largest element, read as signed integers
  function automatic logic [BW-1:0] ref_max(input logic [W-1:0] v);
    int mx;
    mx = int'($signed(v[BW-1:0]));
    for (int k = 1; k < N; k++)
      if (int'($signed(v[k*BW +: BW])) > mx) mx = int'($signed(v[k*BW +: BW]));
    return BW'(mx);
  endfunction

  // Subtractor arithmetic: (x - max) >>> 2 per element
  function automatic logic [W-1:0] sub_fn(input logic [W-1:0] v, input logic [BW-1:0] m);
    logic [W-1:0] r;
    int mi;
    mi = int'($signed(m));
    for (int k = 0; k < N; k++)
      r[k*BW +: BW] = BW'((int'($signed(v[k*BW +: BW])) - mi) >>> 2);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec(input int mode);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: v[k*BW +: BW] = BW'($urandom);
        1: v[k*BW +: BW] = BW'($urandom_range(0, 3) * 16'h0400 - 16'h0800);
        2: v[k*BW +: BW] = ($urandom_range(0, 7) == 0) ? BW'($urandom) : 16'h8000;
        default: v[k*BW +: BW] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
      endcase
    end
    return v;
  endfunction

  // External subtractor: result appears two cycles after the issue pulse
  initial begin
    i_sub_valid = 1'b0;
    i_sub_data  = '0;
    p1 = 1'b0; p2 = 1'b0; d1 = '0; d2 = '0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!i_rst_n) begin
        p1 = 1'b0; p2 = 1'b0;
        i_sub_valid = stray;
        i_sub_data  = '0;
      end else begin
        i_sub_valid = (p2 && sub_en) || stray;
        i_sub_data  = d2;
        p2 = p1;
        d2 = d1;
        p1 = o_sub_valid;
        d1 = sub_fn(o_sub_data, o_sub_max);
      end
    end
  end

  task automatic run_vector(input logic [W-1:0] vec, input int hold, input string tag);
    logic [BW-1:0] em;
    logic [W-1:0]  ed;
    int            sub_cyc, sub_cnt, val_cyc;
    logic          stable;
    em = ref_max(vec);
    ed = sub_fn(vec, em);
    for (int t = 0; t < 50 && !o_ready; t++) @(negedge i_clk);
    check({tag, "_idle_rdy"}, o_ready, 1);
    i_valid = 1'b1;
    i_data  = vec;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_data  = rand_vec(0);
    check({tag, "_busy"}, {o_ready, o_busy, o_err}, 3'b010);
    sub_cyc = -1; sub_cnt = 0; val_cyc = -1;
    for (int c = 1; c < N + 40; c++) begin
      if (o_sub_valid) begin
        sub_cnt++;
        if (sub_cyc < 0) begin
          sub_cyc = c;
          check({tag, "_sub_max"}, o_sub_max, em);
          check({tag, "_sub_data"}, o_sub_data, vec);
        end
      end
      if (o_valid) begin
        val_cyc = c;
        break;
      end
      @(negedge i_clk);
    end
    check({tag, "_sub_cyc"}, sub_cyc, N);
    check({tag, "_sub_cnt"}, sub_cnt, 1);
    check({tag, "_val_cyc"}, val_cyc, N + 3);
    check({tag, "_data"}, o_data, ed);
    check({tag, "_max"}, o_max, em);
    stable = 1'b1;
    if (hold > 0) i_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      stable &= o_valid && !o_ready && (o_data == ed) && (o_max == em);
    end
    check({tag, "_hold"}, stable, 1);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check({tag, "_release"}, {o_valid, o_ready, o_busy}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    logic         ok;
    int           err_cyc;
    logic         saw_val;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    repeat (3) @(negedge i_clk);
    check("rst_ctl", {o_ready, o_busy, o_valid, o_sub_valid, o_err}, 5'b10000);
    check("rst_data", o_data, 0);
    check("rst_max", {o_max, o_sub_max}, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_ctl", {o_ready, o_busy, o_valid, o_sub_valid, o_err}, 5'b10000);
    check("post_rst_sub", o_sub_data, 0);

    // ramp k*0x100: max 0x1F00, o_data[0]=0xF840, o_data[31]=0
    for (int k = 0; k < N; k++) v[k*BW +: BW] = BW'(k * 16'h0100);
    run_vector(v, 0, "ramp");

    // single 0x7FFF in a field of 0x8000
    for (int k = 0; k < N; k++) v[k*BW +: BW] = 16'h8000;
    if (N > 17) v[17*BW +: BW] = 16'h7FFF;
    run_vector(v, 2, "pos_ext");

    // all 0x8000
    for (int k = 0; k < N; k++) v[k*BW +: BW] = 16'h8000;
    run_vector(v, 0, "neg_ext");

    // ties everywhere
    for (int k = 0; k < N; k++) v[k*BW +: BW] = 16'h1234;
    run_vector(v, 1, "ties");

    // backpressure 10 cycles with a competing i_valid
    run_vector(rand_vec(0), 10, "bp");

    for (int i = 0; i < 20; i++)
      run_vector(rand_vec($urandom_range(0, 3)), $urandom_range(0, 4), "rnd");

    // reset in cycle 10 of MAXS, then a stray subtractor pulse
    i_valid = 1'b1;
    i_data  = rand_vec(0);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {o_ready, o_busy, o_valid, o_sub_valid, o_err}, 5'b10000);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_sub", o_sub_data, 0);
    check("mid_rst_max", {o_max, o_sub_max}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #2 stray = 1'b1;
    @(posedge i_clk);
    #2 stray = 1'b0;
    ok = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge i_clk);
      ok &= !o_valid && !o_busy && o_ready;
    end
    check("stray_ignored", ok, 1);
    run_vector(rand_vec(0), 1, "after_rst");

`ifdef SOFTMAX_SUB_CTRL_TIMEOUT_EN
    sub_en  = 1'b0;
    i_valid = 1'b1;
    i_data  = rand_vec(0);
    @(negedge i_clk);
    i_valid = 1'b0;
    err_cyc = -1;
    saw_val = 1'b0;
    for (int c = 1; c < N + 60; c++) begin
      if (o_valid) saw_val = 1'b1;
      if (o_err) begin
        err_cyc = c;
        break;
      end
      @(negedge i_clk);
    end
    check("tmo_cyc", err_cyc, N + 16);
    check("tmo_no_valid", saw_val, 0);
    check("tmo_idle", {o_ready, o_busy}, 2'b10);
    repeat (3) @(negedge i_clk);
    check("tmo_sticky", o_err, 1);
    sub_en = 1'b1;
    run_vector(rand_vec(0), 0, "tmo_clear");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
